// File: rtl/alu_exec_unit.sv
// Handshaked WIDTH-bit ALU whose results return in order through a response FIFO.
// Optional feature macro ALU_OVERFLOW_EN adds a stored signed-overflow flag and the rsp_overflow port.
module alu_exec_unit #(
    parameter int WIDTH      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [2:0]       req_sel,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_carry,
`ifdef ALU_OVERFLOW_EN
    output logic             rsp_overflow,
`endif
    output logic             rsp_zero
);

    localparam int PW = $clog2(FIFO_DEPTH);
`ifdef ALU_OVERFLOW_EN
    localparam int EW = WIDTH + 3;
`else
    localparam int EW = WIDTH + 2;
`endif
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(FIFO_DEPTH);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_result;
    logic             w_carry;
    logic             w_zero;
    logic [EW-1:0]    w_entry;
    logic [EW-1:0]    w_head;
    logic             w_push;
    logic             w_pop;

    logic [EW-1:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;

    assign w_sum  = {1'b0, req_a} + {1'b0, req_b};
    assign w_diff = {1'b0, req_a} - {1'b0, req_b};

    // The top bit of the extended difference is the borrow, so carry is its inverse.
    always_comb begin
        w_result = '0;
        w_carry  = 1'b0;
        case (req_sel)
            3'b000: begin
                w_result = w_sum[WIDTH-1:0];
                w_carry  = w_sum[WIDTH];
            end
            3'b001: begin
                w_result = w_diff[WIDTH-1:0];
                w_carry  = ~w_diff[WIDTH];
            end
            3'b010: w_result = req_a & req_b;
            3'b011: w_result = req_a | req_b;
            3'b100: w_result = req_a ^ req_b;
            3'b101: w_result = ~req_a;
            3'b110: begin
                w_result = {req_a[WIDTH-2:0], 1'b0};
                w_carry  = req_a[WIDTH-1];
            end
            3'b111: begin
                w_result = {1'b0, req_a[WIDTH-1:1]};
                w_carry  = req_a[0];
            end
        endcase
    end

    assign w_zero = (w_result == '0);

`ifdef ALU_OVERFLOW_EN
    logic w_overflow;

    always_comb begin
        w_overflow = 1'b0;
        if (req_sel == 3'b000)
            w_overflow = (req_a[WIDTH-1] == req_b[WIDTH-1]) && (w_result[WIDTH-1] != req_a[WIDTH-1]);
        else if (req_sel == 3'b001)
            w_overflow = (req_a[WIDTH-1] != req_b[WIDTH-1]) && (w_result[WIDTH-1] != req_a[WIDTH-1]);
    end

    assign w_entry      = {w_result, w_carry, w_zero, w_overflow};
    assign rsp_overflow = w_head[0];
`else
    assign w_entry = {w_result, w_carry, w_zero};
`endif

    assign req_ready = (r_count != FULL_COUNT);
    assign rsp_valid = (r_count != '0);
    assign w_push    = req_valid & req_ready;
    assign w_pop     = rsp_valid & rsp_ready;

    assign w_head     = r_mem[r_rd_ptr];
    assign rsp_result = w_head[EW-1 -: WIDTH];
    assign rsp_carry  = w_head[EW-WIDTH-1];
    assign rsp_zero   = w_head[EW-WIDTH-2];

    // Storage is cleared on reset so the head reads as zero until the first push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                r_mem[i] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_entry;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit (WIDTH=4, FIFO_DEPTH=4); overflow scenario builds only with ALU_OVERFLOW_EN.
module tb_alu_exec_unit;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_a;
    logic [3:0] req_b;
    logic [2:0] req_sel;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_result;
    logic       rsp_carry;
    logic       rsp_zero;
`ifdef ALU_OVERFLOW_EN
    logic       rsp_overflow;
`endif

    int checks   = 0;
    int failures = 0;

    alu_exec_unit #(.WIDTH(4), .FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_sel      (req_sel),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_carry    (rsp_carry),
`ifdef ALU_OVERFLOW_EN
        .rsp_overflow (rsp_overflow),
`endif
        .rsp_zero     (rsp_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge, away from the active edge.
    task test_reset;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_sel   = '0;
        rsp_ready = 1'b0;
        #12;
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_valid_in_reset: got %b expected 0", rsp_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid} !== 2'b10) begin
            failures++;
            $display("[TB] FAIL reset_handshake: got ready=%b valid=%b expected ready=1 valid=0", req_ready, rsp_valid);
        end
        checks++;
        if ({rsp_result, rsp_carry, rsp_zero} !== 6'b0) begin
            failures++;
            $display("[TB] FAIL reset_fields: got res=%b c=%b z=%b expected all 0", rsp_result, rsp_carry, rsp_zero);
        end
    endtask

    task test_all_ops;
        logic [3:0] expRes [8];
        logic       expCarry [8];
        expRes   = '{4'b1000, 4'b0010, 4'b0001, 4'b0111, 4'b0110, 4'b1010, 4'b1010, 4'b0010};
        expCarry = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        rsp_ready = 1'b1;
        req_a     = 4'b0101;
        req_b     = 4'b0011;
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            if (k > 0) begin
                checks++;
                if ({rsp_valid, rsp_result, rsp_carry, rsp_zero} !== {1'b1, expRes[k-1], expCarry[k-1], 1'b0}) begin
                    failures++;
                    $display("[TB] FAIL op_%0d: got v=%b res=%b c=%b z=%b expected v=1 res=%b c=%b z=0",
                             k-1, rsp_valid, rsp_result, rsp_carry, rsp_zero, expRes[k-1], expCarry[k-1]);
                end
            end
            if (k < 8) begin
                req_valid = 1'b1;
                req_sel   = 3'(k);
            end else begin
                req_valid = 1'b0;
            end
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ops_drained: got valid=%b expected 0", rsp_valid);
        end
    endtask

    task test_add_wrap;
        rsp_ready = 1'b0;
        req_a     = 4'b1111;
        req_b     = 4'b0001;
        req_sel   = 3'b000;
        req_valid = 1'b1;
        #1;
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL add_no_comb_path: got valid=%b expected 0", rsp_valid);
        end
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if ({rsp_valid, rsp_result, rsp_carry, rsp_zero} !== 7'b1_0000_1_1) begin
            failures++;
            $display("[TB] FAIL add_wrap: got v=%b res=%b c=%b z=%b expected v=1 res=0000 c=1 z=1",
                     rsp_valid, rsp_result, rsp_carry, rsp_zero);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL add_popped: got valid=%b expected 0", rsp_valid);
        end
    endtask

    task test_backpressure;
        logic [3:0] expHead;
        rsp_ready = 1'b0;
        req_b     = 4'b0000;
        req_sel   = 3'b011;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 1'b1) begin
                failures++;
                $display("[TB] FAIL bp_ready_fill_%0d: got %b expected 1", i, req_ready);
            end
            req_valid = 1'b1;
            req_a     = 4'(i + 1);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            req_a = 4'd5;
            checks++;
            if ({req_ready, rsp_valid, rsp_result} !== {1'b0, 1'b1, 4'd1}) begin
                failures++;
                $display("[TB] FAIL bp_full_hold_%0d: got ready=%b valid=%b res=%0d expected ready=0 valid=1 res=1",
                         i, req_ready, rsp_valid, rsp_result);
            end
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bp_no_passthrough: got ready=%b expected 0", req_ready);
        end
        @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid, rsp_result} !== {1'b1, 1'b1, 4'd2}) begin
            failures++;
            $display("[TB] FAIL bp_ready_rises: got ready=%b valid=%b res=%0d expected ready=1 valid=1 res=2",
                     req_ready, rsp_valid, rsp_result);
        end
        for (int j = 3; j <= 5; j++) begin
            @(negedge clk);
            req_valid = 1'b0;
            expHead   = 4'(j);
            checks++;
            if ({rsp_valid, rsp_result} !== {1'b1, expHead}) begin
                failures++;
                $display("[TB] FAIL bp_drain_%0d: got valid=%b res=%0d expected valid=1 res=%0d",
                         j, rsp_valid, rsp_result, expHead);
            end
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bp_empty: got valid=%b expected 0", rsp_valid);
        end
    endtask

    task test_wrap;
        int q [$];
        rsp_ready = 1'b0;
        req_b     = 4'b0000;
        req_sel   = 3'b011;
        for (int i = 1; i <= 2; i++) begin
            @(negedge clk);
            req_valid = 1'b1;
            req_a     = 4'(i);
            q.push_back(i);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            checks++;
            if ({rsp_valid, rsp_result, req_ready} !== {1'b1, 4'(q[0]), 1'b1}) begin
                failures++;
                $display("[TB] FAIL wrap_cycle_%0d: got valid=%b res=%0d ready=%b expected valid=1 res=%0d ready=1",
                         k, rsp_valid, rsp_result, req_ready, q[0]);
            end
            req_valid = 1'b1;
            req_a     = 4'(k + 3);
            void'(q.pop_front());
            q.push_back(k + 3);
            @(negedge clk);
        end
        req_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({rsp_valid, rsp_result} !== {1'b1, 4'(q[0])}) begin
                failures++;
                $display("[TB] FAIL wrap_drain_%0d: got valid=%b res=%0d expected valid=1 res=%0d",
                         k, rsp_valid, rsp_result, q[0]);
            end
            void'(q.pop_front());
            @(negedge clk);
        end
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL wrap_count: got valid=%b expected 0 after two drains", rsp_valid);
        end
    endtask

    task test_reset_mid;
        rsp_ready = 1'b0;
        req_b     = 4'b0000;
        req_sel   = 3'b011;
        for (int i = 7; i <= 9; i++) begin
            @(negedge clk);
            req_valid = 1'b1;
            req_a     = 4'(i);
        end
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if ({rsp_valid, rsp_result} !== {1'b1, 4'd7}) begin
            failures++;
            $display("[TB] FAIL rmid_queued: got valid=%b res=%0d expected valid=1 res=7", rsp_valid, rsp_result);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rmid_async: got valid=%b expected 0", rsp_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_result} !== {1'b1, 1'b0, 4'd0}) begin
            failures++;
            $display("[TB] FAIL rmid_release: got ready=%b valid=%b res=%0d expected ready=1 valid=0 res=0",
                     req_ready, rsp_valid, rsp_result);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rmid_no_stale: got valid=%b expected 0", rsp_valid);
        end
        req_valid = 1'b1;
        req_a     = 4'hC;
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if ({rsp_valid, rsp_result} !== {1'b1, 4'hC}) begin
            failures++;
            $display("[TB] FAIL rmid_fresh: got valid=%b res=%h expected valid=1 res=c", rsp_valid, rsp_result);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rmid_fresh_popped: got valid=%b expected 0", rsp_valid);
        end
    endtask

`ifdef ALU_OVERFLOW_EN
    task test_overflow;
        logic [3:0] opA [3];
        logic [3:0] opB [3];
        logic [2:0] opS [3];
        logic [3:0] expRes [3];
        logic       expOv [3];
        opA    = '{4'b0111, 4'b1000, 4'b0101};
        opB    = '{4'b0001, 4'b0001, 4'b0011};
        opS    = '{3'b000, 3'b001, 3'b010};
        expRes = '{4'b1000, 4'b0111, 4'b0001};
        expOv  = '{1'b1, 1'b1, 1'b0};
        rsp_ready = 1'b1;
        for (int k = 0; k <= 3; k++) begin
            @(negedge clk);
            if (k > 0) begin
                checks++;
                if ({rsp_valid, rsp_result, rsp_overflow} !== {1'b1, expRes[k-1], expOv[k-1]}) begin
                    failures++;
                    $display("[TB] FAIL ovf_%0d: got valid=%b res=%b ov=%b expected valid=1 res=%b ov=%b",
                             k-1, rsp_valid, rsp_result, rsp_overflow, expRes[k-1], expOv[k-1]);
                end
            end
            if (k < 3) begin
                req_valid = 1'b1;
                req_a     = opA[k];
                req_b     = opB[k];
                req_sel   = opS[k];
            end else begin
                req_valid = 1'b0;
            end
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_all_ops();
        test_add_wrap();
        test_backpressure();
        test_wrap();
        test_reset_mid();
`ifdef ALU_OVERFLOW_EN
        test_overflow();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
